mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Control FSM that sequences a multicycle MIPS datapath: shared instruction/data memory, IR, ALUOut register and a single ALU reused across cycles.
- Decodes opcode/funct from the IR and drives every mux select and write enable in the datapath.
- Supports lw, sw, beq, addi, j and R-type add/sub/and/or/slt.
- Inserts memory wait states through a ready handshake.

Parameters:
- None. Opcode, funct and state encodings are fixed below.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_op  in  6  IR[31:26]
- i_funct  in  6  IR[5:0]
- i_zero  in  1  ALU zero flag
- i_mem_ready  in  1  memory access completes this cycle
- o_iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- o_mem_req  out  1  memory access active
- o_mem_write  out  1  memory write enable
- o_ir_write  out  1  IR load enable
- o_reg_dst  out  1  write register select: 1 = rd, 0 = rt
- o_mem_to_reg  out  1  register write data select: 1 = data reg, 0 = ALUOut
- o_reg_write  out  1  register file write enable
- o_alu_src_a  out  1  ALU A select: 0 = PC, 1 = RD1
- o_alu_src_b  out  2  ALU B select: 00 = RD2, 01 = constant 4, 10 = signImm, 11 = signImm<<2
- o_alu_control  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- o_pc_src  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- o_pc_en  out  1  PC load enable
- o_state  out  4  current state, for debug
- o_retire  out  1  one-cycle pulse in the final cycle of each legal instruction
- o_illegal  out  1  one-cycle pulse on an unsupported opcode or funct

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, next state is FETCH.
- Only the state register is sequential. Outputs are a Moore decode of state, except o_pc_en, o_ir_write, o_mem_write and o_retire, which are qualified by inputs as listed below.
- Unlisted outputs in any state are 0.
- Reset: while i_rst is high, state=FETCH and o_pc_en, o_ir_write, o_mem_write, o_reg_write, o_mem_req, o_retire and o_illegal are all forced 0. Mux selects show FETCH values. Reset asserted mid-instruction aborts it with no further writes.
- FETCH: iord=0, mem_req=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00.
  - ir_write=pc_en=i_mem_ready.
  - Stay in FETCH while !i_mem_ready; go to DECODE when i_mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target into ALUOut).
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode, or opcode 000000 with an unsupported funct: o_illegal=1, next state FETCH, no writes.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010. Next state MEMREAD if opcode is lw, else MEMWRITE.
- MEMREAD: iord=1, mem_req=1. Stay while !i_mem_ready; then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. Next state FETCH.
- MEMWRITE: iord=1, mem_req=1, mem_write=1, held until i_mem_ready. retire=i_mem_ready. Go to FETCH when i_mem_ready.
- EXECUTE: alu_src_a=1, alu_src_b=00.
  - alu_control from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - Next state ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, retire=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=i_zero, retire=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010. Next state ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, retire=1. Next state FETCH.
- JUMP: pc_src=10, pc_en=1, retire=1. Next state FETCH.
- Latencies in cycles with zero memory wait:
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3
  - Each cycle i_mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- i_op and i_funct are sampled only in DECODE, MEMADR and EXECUTE. The IR is stable in those states because ir_write=0.

Test Plan:
- Reset: assert i_rst mid-MEMWRITE -> state=0 asynchronously, o_mem_write=0 immediately; release with i_mem_ready=1 -> FETCH pulses o_ir_write=1, o_pc_en=1.
- lw, i_op=100011, i_mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; o_retire pulses once.
- sw with i_mem_ready low for 3 cycles in MEMWRITE -> o_mem_write high for 4 consecutive cycles; retire on the 4th; o_reg_write never asserted.
- R-type sub, i_op=0, i_funct=100010 -> alu_control=110 in EXECUTE; ALUWB has reg_dst=1, reg_write=1.
- beq, i_op=000100: with i_zero=1 -> o_pc_en=1, pc_src=01 in BRANCH; with i_zero=0 -> o_pc_en=0; both take 3 cycles.
- Illegal, i_op=111111 (and separately R-type funct=000000) -> o_illegal pulses in DECODE, returns to FETCH, no reg_write/mem_write/pc_en, no retire.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS datapath and its control FSM.
// master: datapath side (drives IR fields, ALU zero flag, memory ready)
// slave : controller side (drives mux selects, write enables, debug state)
interface mips_multicycle_ctrl_if;
  logic [5:0] i_op;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_iord;
  logic       o_mem_req;
  logic       o_mem_write;
  logic       o_ir_write;
  logic       o_reg_dst;
  logic       o_mem_to_reg;
  logic       o_reg_write;
  logic       o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [2:0] o_alu_control;
  logic [1:0] o_pc_src;
  logic       o_pc_en;
  logic [3:0] o_state;
  logic       o_retire;
  logic       o_illegal;

  modport master (
    output i_op, i_funct, i_zero, i_mem_ready,
    input  o_iord, o_mem_req, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
           o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_control, o_pc_src,
           o_pc_en, o_state, o_retire, o_illegal
  );

  modport slave (
    input  i_op, i_funct, i_zero, i_mem_ready,
    output o_iord, o_mem_req, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
           o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_control, o_pc_src,
           o_pc_en, o_state, o_retire, o_illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for a multicycle MIPS datapath (lw, sw, beq, addi, j, add/sub/and/or/slt).
// Ports: i_clk (rising edge), i_rst (async, active-high), bus (slave modport):
//   inputs  : IR opcode/funct, ALU zero flag, memory ready handshake
//   outputs : datapath mux selects, write enables, debug state, retire/illegal pulses
// Only the state register is a flop; outputs decode the current state, with the
// PC/IR/memory write enables and retire qualified by zero/ready where needed.
module mips_multicycle_ctrl (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mips_multicycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     state_q, state_d;
  logic       funct_ok;
  logic [2:0] r_alu;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // R-type funct decode, shared by DECODE (legality) and EXECUTE (ALU op)
  always_comb begin
    funct_ok = 1'b1;
    r_alu    = 3'b010;
    case (bus.i_funct)
      6'b100000: r_alu = 3'b010;
      6'b100010: r_alu = 3'b110;
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b101010: r_alu = 3'b111;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d           = S_FETCH;
    bus.o_iord        = 1'b0;
    bus.o_mem_req     = 1'b0;
    bus.o_mem_write   = 1'b0;
    bus.o_ir_write    = 1'b0;
    bus.o_reg_dst     = 1'b0;
    bus.o_mem_to_reg  = 1'b0;
    bus.o_reg_write   = 1'b0;
    bus.o_alu_src_a   = 1'b0;
    bus.o_alu_src_b   = 2'b00;
    bus.o_alu_control = 3'b000;
    bus.o_pc_src      = 2'b00;
    bus.o_pc_en       = 1'b0;
    bus.o_retire      = 1'b0;
    bus.o_illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.o_mem_req     = 1'b1;
        bus.o_alu_src_b   = 2'b01;
        bus.o_alu_control = 3'b010;
        bus.o_ir_write    = bus.i_mem_ready;
        bus.o_pc_en       = bus.i_mem_ready;
        state_d           = bus.i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // PC + (signImm<<2) parked in ALUOut for a possible branch
        bus.o_alu_src_b   = 2'b11;
        bus.o_alu_control = 3'b010;
        case (bus.i_op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            state_d       = funct_ok ? S_EXECUTE : S_FETCH;
            bus.o_illegal = !funct_ok;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: bus.o_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        bus.o_alu_src_a   = 1'b1;
        bus.o_alu_src_b   = 2'b10;
        bus.o_alu_control = 3'b010;
        state_d           = (bus.i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.o_iord    = 1'b1;
        bus.o_mem_req = 1'b1;
        state_d       = bus.i_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        bus.o_mem_to_reg = 1'b1;
        bus.o_reg_write  = 1'b1;
        bus.o_retire     = 1'b1;
      end
      S_MEMWRITE: begin
        bus.o_iord      = 1'b1;
        bus.o_mem_req   = 1'b1;
        bus.o_mem_write = 1'b1;
        bus.o_retire    = bus.i_mem_ready;
        state_d         = bus.i_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        bus.o_alu_src_a   = 1'b1;
        bus.o_alu_control = r_alu;
        state_d           = S_ALUWB;
      end
      S_ALUWB: begin
        bus.o_reg_dst   = 1'b1;
        bus.o_reg_write = 1'b1;
        bus.o_retire    = 1'b1;
      end
      S_BRANCH: begin
        bus.o_alu_src_a   = 1'b1;
        bus.o_alu_control = 3'b110;
        bus.o_pc_src      = 2'b01;
        bus.o_pc_en       = bus.i_zero;
        bus.o_retire      = 1'b1;
      end
      S_ADDIEX: begin
        bus.o_alu_src_a   = 1'b1;
        bus.o_alu_src_b   = 2'b10;
        bus.o_alu_control = 3'b010;
        state_d           = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.o_reg_write = 1'b1;
        bus.o_retire    = 1'b1;
      end
      S_JUMP: begin
        bus.o_pc_src = 2'b10;
        bus.o_pc_en  = 1'b1;
        bus.o_retire = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset gates every side effect; selects already read as FETCH
    if (i_rst) begin
      bus.o_pc_en     = 1'b0;
      bus.o_ir_write  = 1'b0;
      bus.o_mem_write = 1'b0;
      bus.o_reg_write = 1'b0;
      bus.o_mem_req   = 1'b0;
      bus.o_retire    = 1'b0;
      bus.o_illegal   = 1'b0;
    end
  end

  assign bus.o_state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: directed instructions, then randomized instruction mix with
// random memory wait states, checked cycle by cycle against an instruction-level model.
module tb_mips_multicycle_ctrl;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 i_clk = ~i_clk;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit funct_legal(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    bus.i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  // Runs one instruction starting in FETCH. fw/mw are wait cycles for the
  // fetch and data memory phases. Model: instruction class -> state path.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                           input int fw, input int mw, input bit z);
    int  path[$];
    bit  rdy[$];
    bit  legal;
    bit  is_mem;
    int  exp_lat;
    int  lat;
    legal  = op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J} || (op == OP_R && funct_legal(funct));
    is_mem = op inside {OP_LW, OP_SW};
    for (int i = 0; i < fw; i++) begin path.push_back(0); rdy.push_back(1'b0); end
    path.push_back(0); rdy.push_back(1'b1);
    path.push_back(1); rdy.push_back(1'($urandom));
    if (legal) begin
      case (op)
        OP_LW, OP_SW: begin
          path.push_back(2); rdy.push_back(1'($urandom));
          for (int i = 0; i < mw; i++) begin
            path.push_back(op == OP_LW ? 3 : 5); rdy.push_back(1'b0);
          end
          path.push_back(op == OP_LW ? 3 : 5); rdy.push_back(1'b1);
          if (op == OP_LW) begin path.push_back(4); rdy.push_back(1'($urandom)); end
        end
        OP_R:    begin path.push_back(6); path.push_back(7); rdy.push_back(1'($urandom)); rdy.push_back(1'($urandom)); end
        OP_ADDI: begin path.push_back(9); path.push_back(10); rdy.push_back(1'($urandom)); rdy.push_back(1'($urandom)); end
        OP_BEQ:  begin path.push_back(8); rdy.push_back(1'($urandom)); end
        default: begin path.push_back(11); rdy.push_back(1'($urandom)); end
      endcase
    end
    // latency from the instruction timing table
    case (op)
      OP_LW:   exp_lat = 5;
      OP_SW:   exp_lat = 4;
      OP_BEQ, OP_J: exp_lat = 3;
      default: exp_lat = 4;
    endcase
    if (!legal) exp_lat = 2;
    exp_lat += fw + (legal && is_mem ? mw : 0);
    lat = 0;
    for (int k = 0; k < path.size(); k++) begin
      int s;
      bit last;
      s    = path[k];
      last = (k == path.size() - 1);
      bus.i_op = op; bus.i_funct = funct; bus.i_mem_ready = rdy[k];
      bus.i_zero = (s == 8) ? z : 1'($urandom);
      @(negedge i_clk);
      chk("state", 8'(bus.o_state), 8'(s));
      chk("mem_req", 8'(bus.o_mem_req), 8'(s == 0 || s == 3 || s == 5));
      chk("ir_write", 8'(bus.o_ir_write), 8'(s == 0 && rdy[k]));
      chk("pc_en", 8'(bus.o_pc_en), 8'((s == 0 && rdy[k]) || (s == 8 && z) || s == 11));
      chk("mem_write", 8'(bus.o_mem_write), 8'(s == 5));
      chk("reg_write", 8'(bus.o_reg_write), 8'(s == 4 || s == 7 || s == 10));
      chk("retire", 8'(bus.o_retire), 8'(legal && last));
      chk("illegal", 8'(bus.o_illegal), 8'(!legal && s == 1));
      if (s == 4)  chk("memwb_mem_to_reg", 8'(bus.o_mem_to_reg), 8'd1);
      if (s == 3 || s == 5) chk("iord", 8'(bus.o_iord), 8'd1);
      if (s == 6)  chk("exec_alu", 8'(bus.o_alu_control), 8'(alu_of(funct)));
      if (s == 7)  chk("aluwb_reg_dst", 8'(bus.o_reg_dst), 8'd1);
      if (s == 8)  chk("branch_pc_src", 8'(bus.o_pc_src), 8'd1);
      if (s == 11) chk("jump_pc_src", 8'(bus.o_pc_src), 8'd2);
      if (s == 1)  chk("decode_src_b", 8'(bus.o_alu_src_b), 8'd3);
      if (lat == 0 && (bus.o_retire || bus.o_illegal)) lat = k + 1;
      @(posedge i_clk); #1;
    end
    chk("latency", 8'(lat), 8'(exp_lat));
  endtask

  initial begin
    bus.i_op = '0; bus.i_funct = '0; bus.i_zero = 1'b0; bus.i_mem_ready = 1'b1;
    // reset state: enables held low even with ready high
    #2;
    chk("rst_state", 8'(bus.o_state), 8'd0);
    chk("rst_ir_write", 8'(bus.o_ir_write), 8'd0);
    chk("rst_pc_en", 8'(bus.o_pc_en), 8'd0);
    chk("rst_mem_req", 8'(bus.o_mem_req), 8'd0);
    chk("rst_src_b", 8'(bus.o_alu_src_b), 8'd1);
    do_reset();

    // directed instructions
    run_instr(OP_LW, 6'b000000, 0, 0, 1'b0);
    run_instr(OP_SW, 6'b000000, 0, 3, 1'b0);
    run_instr(OP_R, 6'b100010, 0, 0, 1'b0);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 1'b1);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 1'b0);
    run_instr(OP_ADDI, 6'b000000, 2, 0, 1'b0);
    run_instr(OP_J, 6'b000000, 1, 0, 1'b0);
    run_instr(6'b111111, 6'b100000, 0, 0, 1'b0);
    run_instr(OP_R, 6'b000000, 0, 0, 1'b0);

    // reset in the middle of a held MEMWRITE
    bus.i_op = OP_SW; bus.i_mem_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 bus.i_mem_ready = 1'b0;
    chk("mw_state", 8'(bus.o_state), 8'd5);
    chk("mw_write", 8'(bus.o_mem_write), 8'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_state", 8'(bus.o_state), 8'd0);
    chk("mid_rst_mem_write", 8'(bus.o_mem_write), 8'd0);
    chk("mid_rst_retire", 8'(bus.o_retire), 8'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; bus.i_mem_ready = 1'b1;
    #1;
    chk("post_rst_ir_write", 8'(bus.o_ir_write), 8'd1);
    chk("post_rst_pc_en", 8'(bus.o_pc_en), 8'd1);
    @(posedge i_clk); #1;
    chk("post_rst_decode", 8'(bus.o_state), 8'd1);
    do_reset();

    // randomized mix
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, funct;
      int sel;
      sel = $urandom_range(0, 7);
      funct = 6'($urandom);
      case (sel)
        0: op = OP_LW;
        1: op = OP_SW;
        2: begin
          op = OP_R;
          case ($urandom_range(0, 4))
            0: funct = 6'b100000;
            1: funct = 6'b100010;
            2: funct = 6'b100100;
            3: funct = 6'b100101;
            default: funct = 6'b101010;
          endcase
        end
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        6: op = OP_R;
        default: begin
          op = 6'($urandom);
          while (op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J}) op = 6'($urandom);
        end
      endcase
      run_instr(op, funct, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
